// File: rtl/iterative_shift_unit.sv
// -----------------------------------------------------------------------------
// iterative_shift_unit
//
// Purpose:
//   Sequential shifter that moves operand a by amount b one bit per clock.
//   Supports SLL, SRL, SRA (sign fill) and ROL. It gives the same results as a
//   combinational shifter, using a single-bit step datapath instead of a
//   barrel network. One operation is in flight at a time; both sides use a
//   valid/ready handshake.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset (discards any job)
//   in_valid   in   1      a/b/op valid
//   in_ready   out  1      unit can accept a job (IDLE and not in reset)
//   a          in   WIDTH  operand
//   b          in   AMT_W  shift amount (unsigned, may exceed WIDTH-1)
//   op         in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid  out  1      y holds the final result
//   out_ready  in   1      consumer takes y
//   y          out  WIDTH  result register (keeps its value after handshake)
//   busy       out  1      high while shifting or holding a result
// -----------------------------------------------------------------------------
module iterative_shift_unit #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  // Count must be able to hold WIDTH itself (clamped linear shifts).
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   y_reg, y_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [1:0]         op_reg, op_next;

  logic [31:0]        b_wide;
  logic [CNT_W-1:0]   n_eff;
  logic [WIDTH-1:0]   step_y;

  assign b_wide = 32'(b);

  // Effective step count. Linear shifts saturate at WIDTH (everything has
  // been shifted out by then); rotates wrap, and since WIDTH is a power of
  // two the modulo reduces to a mask.
  always_comb begin
    n_eff = '0;
    if (op == OP_ROL) begin
      n_eff = CNT_W'(b_wide & 32'(WIDTH - 1));
    end else if (b_wide >= 32'(WIDTH)) begin
      n_eff = CNT_W'(WIDTH);
    end else begin
      n_eff = CNT_W'(b_wide);
    end
  end

  // One-bit step on the working register, selected by the latched op.
  always_comb begin
    step_y = y_reg;
    case (op_reg)
      OP_SLL:  step_y = {y_reg[WIDTH-2:0], 1'b0};
      OP_SRL:  step_y = {1'b0, y_reg[WIDTH-1:1]};
      OP_SRA:  step_y = {y_reg[WIDTH-1], y_reg[WIDTH-1:1]};
      OP_ROL:  step_y = {y_reg[WIDTH-2:0], y_reg[WIDTH-1]};
      default: step_y = y_reg;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    count_next = count_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          y_next     = a;
          op_next    = op;
          count_next = n_eff;
          // Zero-length jobs skip the shift phase entirely.
          state_next = (n_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        y_next     = step_y;
        count_next = count_reg - CNT_W'(1);
        // The final step is applied on the same edge that enters DONE.
        if (count_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      count_reg <= '0;
      op_reg    <= OP_SLL;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      count_reg <= count_next;
      op_reg    <= op_next;
    end
  end

  // in_ready is masked by rst so nothing looks accepted on a reset edge.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign y         = y_reg;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_iterative_shift_unit
//
// Purpose:
//   Self-checking bench for iterative_shift_unit (WIDTH=4, AMT_W=4). A driver
//   issues directed jobs with hand-computed results and pushes the expected
//   result and step count into a scoreboard queue; a monitor pops and compares
//   each time out_valid rises, checking both y and the latency from accept.
// -----------------------------------------------------------------------------
module tb_iterative_shift_unit;

  localparam int WIDTH = 4;
  localparam int AMT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;

  iterative_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  typedef struct {
    logic [WIDTH-1:0] exp_y;
    int               exp_lat;
    int               acc;
    string            name;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: compare on each rising edge of out_valid.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_out: out_valid with no job pending, y=%b (cycle %0d)", y, cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val({e.name, "_y"}, int'(y), int'(e.exp_y));
        check_val({e.name, "_lat"}, cycle - e.acc, e.exp_lat);
        check_val({e.name, "_in_ready_low"}, int'(in_ready), 0);
        $display("txn %s: y=%b exp=%b lat=%0d exp_lat=%0d", e.name, y, e.exp_y,
                 cycle - e.acc, e.exp_lat);
      end
    end
    prev_ov = out_valid && !rst;
  end

  // Wait (bounded) at negedges until in_ready is high.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!in_ready) check_val({name, "_ready_timeout"}, 0, 1);
  endtask

  // Issue a job; returns once the accept edge has passed and expectation is queued.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [AMT_W-1:0] tb,
                       input logic [1:0] top, input logic [WIDTH-1:0] ey,
                       input int en, input string name);
    exp_t e;
    wait_ready(name);
    a        = ta;
    b        = tb;
    op       = top;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.exp_y   = ey;
    e.exp_lat = en;
    e.acc     = cycle;
    e.name    = name;
    sb.push_back(e);
    in_valid = 1'b0;
    // Later changes to inputs must not affect the job.
    a  = ~ta;
    b  = 4'd1;
    op = ~top;
  endtask

  // Wait (bounded) until the monitor has consumed the expectation.
  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    if (sb.size() != 0) begin
      check_val({name, "_result_timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [AMT_W-1:0] tb,
                        input logic [1:0] top, input logic [WIDTH-1:0] ey,
                        input int en, input string name);
    issue(ta, tb, top, ey, en, name);
    wait_result(name);
  endtask

  typedef struct {
    logic [WIDTH-1:0] ta;
    logic [AMT_W-1:0] tb;
    logic [1:0]       top;
    logic [WIDTH-1:0] ey;
    int               en;
    string            name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 2'b00;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_y", int'(y), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_in_ready_during_rst", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready_after", int'(in_ready), 1);

    // Directed vectors: a, b, op, expected y, expected steps.
    vecs.push_back('{4'b1011, 4'd2,  2'b00, 4'b1100, 2, "sll_b2"});
    vecs.push_back('{4'b1011, 4'd9,  2'b10, 4'b1111, 4, "sra_b9"});
    vecs.push_back('{4'b1011, 4'd9,  2'b01, 4'b0000, 4, "srl_b9"});
    vecs.push_back('{4'b1001, 4'd5,  2'b11, 4'b0011, 1, "rol_b5"});
    vecs.push_back('{4'b1001, 4'd4,  2'b11, 4'b1001, 0, "rol_b4"});
    vecs.push_back('{4'b0011, 4'd15, 2'b00, 4'b0000, 4, "sll_b15"});
    vecs.push_back('{4'b1111, 4'd4,  2'b00, 4'b0000, 4, "sll_b4"});
    vecs.push_back('{4'b0101, 4'd1,  2'b10, 4'b0010, 1, "sra_pos_b1"});
    vecs.push_back('{4'b0111, 4'd2,  2'b10, 4'b0001, 2, "sra_pos_b2"});
    vecs.push_back('{4'b1000, 4'd3,  2'b10, 4'b1111, 3, "sra_neg_b3"});
    vecs.push_back('{4'b1000, 4'd3,  2'b01, 4'b0001, 3, "srl_b3"});
    vecs.push_back('{4'b1000, 4'd3,  2'b11, 4'b0100, 3, "rol_b3"});
    vecs.push_back('{4'b0110, 4'd7,  2'b11, 4'b0011, 3, "rol_b7"});
    vecs.push_back('{4'b1101, 4'd0,  2'b00, 4'b1101, 0, "sll_b0"});
    vecs.push_back('{4'b1010, 4'd0,  2'b10, 4'b1010, 0, "sra_b0"});

    foreach (vecs[i]) begin
      run_op(vecs[i].ta, vecs[i].tb, vecs[i].top, vecs[i].ey, vecs[i].en, vecs[i].name);
    end

    // b==0 SRL: result right after the accept edge; busy/in_ready timing.
    issue(4'b0110, 4'd0, 2'b01, 4'b0110, 0, "srl_b0");
    check_val("srl_b0_busy", int'(busy), 1);
    check_val("srl_b0_in_ready", int'(in_ready), 0);
    wait_result("srl_b0");
    @(posedge clk);
    #1;
    check_val("srl_b0_idle_busy", int'(busy), 0);
    check_val("srl_b0_idle_in_ready", int'(in_ready), 1);

    // Backpressure: hold out_ready low for 3 cycles in DONE, pulse in_valid.
    out_ready = 1'b0;
    issue(4'b0001, 4'd1, 2'b00, 4'b0010, 1, "bp_sll");
    wait_result("bp_sll");
    for (int k = 0; k < 3; k++) begin
      check_val("bp_out_valid", int'(out_valid), 1);
      check_val("bp_y_stable", int'(y), 4'b0010);
      check_val("bp_in_ready", int'(in_ready), 0);
      a        = 4'b1111;
      b        = 4'd0;
      op       = 2'b00;
      in_valid = (k != 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_after_out_valid", int'(out_valid), 0);
    check_val("bp_after_y_kept", int'(y), 4'b0010);
    check_val("bp_after_in_ready", int'(in_ready), 1);
    check_val("bp_after_busy", int'(busy), 0);
    $display("txn bp_handshake: y=%b out_valid=%b", y, out_valid);

    // Reset in SHIFT after one step discards the job.
    wait_ready("rst_mid");
    a        = 4'b1000;
    b        = 4'd3;
    op       = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);          // accept
    #1;
    in_valid = 1'b0;
    @(posedge clk);          // first step
    @(negedge clk);
    check_val("rst_mid_step1_y", int'(y), 4'b1100);
    check_val("rst_mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_mid_y", int'(y), 0);
    check_val("rst_mid_out_valid", int'(out_valid), 0);
    check_val("rst_mid_in_ready", int'(in_ready), 1);
    check_val("rst_mid_busy_low", int'(busy), 0);
    $display("txn rst_mid: y=%b out_valid=%b in_ready=%b", y, out_valid, in_ready);
    // Give a faulty design time to emit a stray result for the dropped job.
    repeat (6) @(negedge clk);

    // A fresh job afterwards completes normally.
    run_op(4'b0011, 4'd2, 2'b00, 4'b1100, 2, "post_rst_sll");

    repeat (3) @(negedge clk);
    check_val("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 10000", cycle);
    $fatal(1, "watchdog expired");
  end

endmodule
